lifo_arb: RTL
=============

# lifo_arb

Arbiter and guard for one shared `lifo_se` stack instance. It sits between two requesters (A: core sequencer, B: debug/monitor port) and the stack's `i_se`/`i_data` inputs. Each cycle it grants at most one stack operation, using round-robin priority with an optional ownership lock. It tracks stack depth and suppresses any operation that would underflow or overflow, reporting it as an error.

## Interface
Parameters:
- `WIDTH`, 8, bits per stack element; must match the stack instance.
- `DEPTH`, 12, number of stack elements; must match the stack instance.

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst_n`  in  1  reset; synchronous and active-low.
- `i_a_req`  in  1  requester A has an operation pending.
- `i_a_se`  in  3  requester A stack-effect code.
- `i_a_data`  in  WIDTH  requester A data, used by PUSH and RPLC.
- `i_a_lock`  in  1  A keeps ownership after its granted operation.
- `o_a_ack`  out  1  A's operation is consumed this cycle (executed or rejected).
- `i_b_req`, `i_b_se`, `i_b_data`, `i_b_lock`, `o_b_ack`: same as A, for requester B.
- `i_s0`  in  WIDTH  stack top-of-stack value.
- `o_se`  out  3  stack-effect code to the stack.
- `o_data`  out  WIDTH  data to the stack.
- `o_depth`  out  $clog2(DEPTH+1)  current element count.
- `o_owner`  out  2  lock holder: 00 none, 01 A, 10 B.
- `o_err`  out  1  sticky error flag.
- `o_err_code`  out  4  {requester bit (0=A, 1=B), rejected 3-bit code}, captured on the first error.

## Operation
- Stack-effect codes: NONE=0, DROP=1, PUSH=2, RPLC=3, SWAP=4, OVER=5, ZDUP=6, ROT3=7.
- A request with code NONE is acked immediately, with no stack action and no depth change.
- Ownership state machine:
  - States: FREE, LOCK_A, LOCK_B.
  - FREE: if only one requester is asserting, grant it. If both are asserting, grant the requester that was not granted last. The last-granted register resets to B, so A wins the first tie.
  - A granted operation with that requester's lock=1 moves the state to LOCK_x. With lock=0 the state stays FREE.
  - LOCK_x: only requester x may be granted; the other requester waits with no ack.
  - LOCK_x exits to FREE at the end of a cycle in which x is granted with lock=0.
  - LOCK_x also exits to FREE after a cycle in which x has req=0 and lock=0.
  - The last-granted register updates on every grant.
- Legality check, using the current depth d (pre-operation value):
  - DROP: requires d≥1; new depth d−1.
  - PUSH: requires d<DEPTH; new depth d+1.
  - RPLC: requires d≥1; depth unchanged.
  - SWAP: requires d≥2; depth unchanged.
  - OVER: requires d≥2 and d<DEPTH; new depth d+1.
  - ROT3: requires d≥3; depth unchanged.
  - ZDUP: requires d≥1. If `i_s0`≠0 it also requires d<DEPTH, and the new depth is d+1. If `i_s0`=0 the depth is unchanged.
- Legal grant: drive `o_se` with the code and `o_data` with the granted requester's data, assert that requester's ack, and update `o_depth` at the clock edge.
- Illegal grant:
  - Drive `o_se`=NONE and assert the ack anyway (the request is consumed); depth is unchanged.
  - If `o_err` is 0, set `o_err` and capture `o_err_code`. Later errors do not overwrite it.
  - Lock handling and round-robin state update as for a legal grant.
- When no operation is granted: `o_se`=NONE and `o_data`=0.

## Timing
- Grant, ack, `o_se` and `o_data` are combinational from the requests and registered state, all in the same cycle as the request. The stack executes at the same clock edge at which `o_depth`, the owner state and the error state update.
- A requester holds req, se, data and lock stable until it sees its ack. Changing them before the ack is a protocol violation with undefined result.
- Throughput: one operation per cycle. A requester may issue back-to-back operations.
- Reset (`i_rst_n`=0 at a clock edge) sets:
  - `o_depth`=0, owner state FREE, last-granted=B, `o_err`=0, `o_err_code`=0.
- While `i_rst_n`=0: `o_se`=NONE, `o_data`=0, both acks 0.
- Reset in the middle of a lock or a multi-operation sequence discards all state. Stack contents are not cleared, but they are logically empty because depth=0.
- `o_depth` never exceeds DEPTH and never wraps below 0.

## Test plan
- Reset, then A issues PUSH 0x11, PUSH 0x22 on consecutive cycles: `o_a_ack`=1 in each cycle, `o_se`=2 with `o_data`=0x11 then 0x22, `o_depth` goes 1 then 2, `i_s0`=0x22.
- Both requesters assert PUSH every cycle with lock=0: grants alternate A, B, A, B starting with A. `o_depth` increments by 1 per cycle until 12. The next PUSH gets ack with `o_se`=0, `o_err`=1, and `o_err_code`=4'b0010 or 4'b1010 depending on which requester was granted.
- A holds lock=1 for 3 PUSHes while B requests DROP throughout: `o_owner`=01 and `o_b_ack`=0 until A's third PUSH is issued with lock=0. B is granted DROP on the next cycle, and `o_depth` goes 3 then 2.
- From depth 0, A issues DROP, then ROT3 at depth 2, then SWAP at depth 2: DROP and ROT3 are acked with `o_se`=0 and no depth change. `o_err_code`=4'b0001 (the first error) and stays there through the ROT3 reject. SWAP executes.
- ZDUP at depth 1: with `i_s0`=0 the depth stays 1; with `i_s0`=0x05 the depth becomes 2. ZDUP at depth 12 with `i_s0`=0x05 is rejected.
- Assert `i_rst_n`=0 for one cycle while in LOCK_B at depth 5 with `o_err`=1: the next cycle shows depth 0, owner 00, `o_err`=0, and a simultaneous A+B request grants A.

Source files
------------

// File: rtl/lifo_arb.sv
// lifo_arb: grants at most one operation per cycle from requester A or B to a
// shared lifo_se stack. Round-robin with an optional ownership lock. Tracks
// stack depth and rejects (acks without executing) any operation that would
// underflow or overflow, recording the first such rejection in a sticky error.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_a_req/se/data/lock, o_a_ack  requester A (core sequencer)
//   i_b_req/se/data/lock, o_b_ack  requester B (debug/monitor)
//   i_s0                           stack top-of-stack value (used by ZDUP)
//   o_se, o_data                   operation to the stack (combinational)
//   o_depth                        current element count
//   o_owner                        lock holder: 00 none, 01 A, 10 B
//   o_err, o_err_code              sticky error, {requester, rejected code}
module lifo_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_a_req,
  input  logic [2:0]                 i_a_se,
  input  logic [WIDTH-1:0]           i_a_data,
  input  logic                       i_a_lock,
  output logic                       o_a_ack,
  input  logic                       i_b_req,
  input  logic [2:0]                 i_b_se,
  input  logic [WIDTH-1:0]           i_b_data,
  input  logic                       i_b_lock,
  output logic                       o_b_ack,
  input  logic [WIDTH-1:0]           i_s0,
  output logic [2:0]                 o_se,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic [1:0]                 o_owner,
  output logic                       o_err,
  output logic [3:0]                 o_err_code
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  localparam logic [2:0] SE_NONE = 3'd0;
  localparam logic [2:0] SE_DROP = 3'd1;
  localparam logic [2:0] SE_PUSH = 3'd2;
  localparam logic [2:0] SE_RPLC = 3'd3;
  localparam logic [2:0] SE_SWAP = 3'd4;
  localparam logic [2:0] SE_OVER = 3'd5;
  localparam logic [2:0] SE_ZDUP = 3'd6;
  localparam logic [2:0] SE_ROT3 = 3'd7;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    LOCK_A = 2'b01,
    LOCK_B = 2'b10
  } own_e;

  own_e            state, state_nxt;
  logic            last_b;
  logic [DW-1:0]   depth, depth_nxt;
  logic            err;
  logic [3:0]      err_code;

  logic            gnt_a, gnt_b, gnt, legal, g_lock;
  logic [2:0]      g_se;
  logic [WIDTH-1:0] g_data;

  // Grant selection: lock holder only, otherwise round-robin on ties
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (i_rst_n) begin
      case (state)
        FREE: begin
          if (i_a_req && i_b_req) begin
            gnt_a = last_b;
            gnt_b = !last_b;
          end else begin
            gnt_a = i_a_req;
            gnt_b = i_b_req;
          end
        end
        LOCK_A:  gnt_a = i_a_req;
        LOCK_B:  gnt_b = i_b_req;
        default: ;
      endcase
    end
  end

  assign gnt    = gnt_a | gnt_b;
  assign g_se   = gnt_b ? i_b_se   : i_a_se;
  assign g_data = gnt_b ? i_b_data : i_a_data;
  assign g_lock = gnt_b ? i_b_lock : i_a_lock;

  // Depth legality and post-operation depth of the granted code
  always_comb begin
    legal     = 1'b1;
    depth_nxt = depth;
    case (g_se)
      SE_NONE: ;
      SE_DROP: begin
        legal     = (depth != '0);
        depth_nxt = depth - DW'(1);
      end
      SE_PUSH: begin
        legal     = (depth != FULL);
        depth_nxt = depth + DW'(1);
      end
      SE_RPLC: legal = (depth >= DW'(1));
      SE_SWAP: legal = (depth >= DW'(2));
      SE_OVER: begin
        legal     = (depth >= DW'(2)) && (depth != FULL);
        depth_nxt = depth + DW'(1);
      end
      SE_ZDUP: begin
        // Zero top-of-stack leaves the stack alone; otherwise it duplicates.
        if (i_s0 == '0) begin
          legal = (depth != '0);
        end else begin
          legal     = (depth != '0) && (depth != FULL);
          depth_nxt = depth + DW'(1);
        end
      end
      SE_ROT3: legal = (depth >= DW'(3));
      default: ;
    endcase
  end

  assign o_a_ack = gnt_a;
  assign o_b_ack = gnt_b;
  assign o_se    = (gnt && legal) ? g_se   : SE_NONE;
  assign o_data  = (gnt && legal) ? g_data : '0;

  // Ownership next state
  always_comb begin
    state_nxt = state;
    case (state)
      FREE: begin
        if (gnt && g_lock) state_nxt = gnt_a ? LOCK_A : LOCK_B;
      end
      // In a lock, the holder is granted exactly when it requests, so both
      // exit conditions (granted with lock=0, idle with lock=0) reduce to lock=0.
      LOCK_A: if (!i_a_lock) state_nxt = FREE;
      LOCK_B: if (!i_b_lock) state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  // State register, depth, round-robin and sticky error
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= FREE;
      last_b   <= 1'b1;
      depth    <= '0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_nxt;
      if (gnt) last_b <= gnt_b;
      if (gnt && legal) depth <= depth_nxt;
      if (gnt && !legal && !err) begin
        err      <= 1'b1;
        err_code <= {gnt_b, g_se};
      end
    end
  end

  assign o_depth    = depth;
  assign o_owner    = state;
  assign o_err      = err;
  assign o_err_code = err_code;

endmodule
